rx_frame_sequencer: RTL and testbench
=====================================

// Module: rx_frame_sequencer
// PURPOSE
//  Sits between the Ethernet RX byte FIFO (valid/ready stream) and ip_parser. Pops one byte per
//  BYTE_GAP cycles and drives ip_parser's eth_* inputs. Enforces frame-length limits, flushes the
//  rest of a frame once ip_parser reports ip_err, and waits for the per-frame verdict
//  (ip_eof/ip_err) before starting the next frame. Keeps saturating good/dropped frame counters.
// PARAMETERS
//  BYTE_GAP         4     cycles between accepted bytes (>=1; 1 = back-to-back)
//  MAX_FRAME_BYTES  1500  max bytes per frame forwarded to ip_parser
//  RESULT_TIMEOUT   64    cycles to wait for ip_eof/ip_err after last byte
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   synchronous active-low reset
//  enable          in   1   1 = may start new frames; 0 = finish current frame, then hold IDLE
//  s_tdata         in   8   FIFO byte (byte_t)
//  s_tvalid        in   1   FIFO byte available
//  s_tlast         in   1   last byte of frame
//  s_tuser         in   1   MAC CRC error, qualified with s_tlast
//  s_tready        out  1   byte accepted when s_tvalid && s_tready
//  eth_data_in     out  8   byte to ip_parser (byte_t)
//  eth_byte_valid  out  1   one-cycle strobe, eth_data_in valid
//  eth_eof         out  1   coincident with eth_byte_valid on last forwarded byte
//  eth_err         out  1   coincident with eth_eof; CRC error or length overrun
//  ip_eof          in   1   ip_parser: frame accepted
//  ip_err          in   1   ip_parser: frame rejected
//  busy            out  1   state != IDLE
//  frames_ok       out  16  count of ip_eof verdicts, saturates at 16'hFFFF
//  frames_dropped  out  16  count of ip_err/timeout/overrun drops, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, gap_cnt 0, byte_cnt 0, counters 0. Reset mid-frame abandons
//   the frame; FIFO bytes left over are not flushed by this block.
//  All outputs are registered. A handshake in cycle N gives eth_byte_valid (+eof/err) in N+1, high
//   for exactly one cycle; eth_data_in holds its value until the next handshake.
//  gap_cnt loads BYTE_GAP-1 on each FEED handshake and decrements to 0.
//  FSM:
//   IDLE : s_tready=0. enable && s_tvalid -> FEED; byte_cnt<=0.
//   FEED : s_tready = (gap_cnt==0). On handshake: forward byte, byte_cnt++.
//          s_tlast: eth_eof=1, eth_err=s_tuser -> WAIT.
//          byte_cnt reaches MAX_FRAME_BYTES without s_tlast: eth_eof=1, eth_err=1,
//            frames_dropped++ -> FLUSH.
//          ip_err seen with no handshake -> FLUSH, frames_dropped++.
//          ip_err in the same cycle as the s_tlast handshake: the byte is not forwarded;
//            frames_dropped++ -> IDLE.
//          ip_err in the same cycle as a non-last handshake: the byte is not forwarded;
//            frames_dropped++ -> FLUSH.
//   FLUSH: s_tready=1 every cycle, bytes discarded, no eth_* strobes.
//          s_tlast handshake -> IDLE. ip_eof/ip_err ignored.
//   WAIT : s_tready=0; timer counts from 0.
//          ip_eof -> frames_ok++ -> IDLE.
//          ip_err -> frames_dropped++ -> IDLE.
//          ip_eof && ip_err together counts as err.
//          timer == RESULT_TIMEOUT-1 -> frames_dropped++ -> IDLE.
//  enable only gates IDLE->FEED; deasserting it mid-frame has no effect on the current frame.
//  Counters saturate and never wrap.
//  ip_eof/ip_err while in IDLE are ignored and not counted.
// TESTING
//  1) Valid 20-byte header + 20-byte payload, s_tvalid held high, BYTE_GAP=4 -> 40 strobes 4
//     cycles apart, eth_eof on byte 40, ip_eof -> frames_ok=1, busy low one cycle later.
//  2) Frame with s_tuser=1 on s_tlast -> eth_eof=eth_err=1 on last strobe; parser ip_err ->
//     frames_dropped=1.
//  3) ip_err injected after byte 5 of a 75-byte frame -> no further strobes, remaining 70 bytes
//     drained with s_tready=1, IDLE after tlast, frames_dropped=1.
//  4) MAX_FRAME_BYTES=32, 40-byte frame -> strobe 32 has eth_eof=eth_err=1, bytes 33..40 flushed,
//     frames_dropped=1.
//  5) No verdict after last byte, RESULT_TIMEOUT=64 -> IDLE after 64 cycles, frames_dropped++.
//     Next, enable=0 with s_tvalid=1 -> stays IDLE, s_tready=0.
//  6) Reset asserted mid-FEED -> all outputs 0 next cycle. Counters preloaded to 16'hFFFE, then
//     three good frames -> frames_ok=16'hFFFF.

Source files
------------

// File: rtl/rx_frame_sequencer.sv
// Paces bytes from the RX FIFO into ip_parser, applies frame-length limits and flushes rejected frames.
// Waits for a per-frame verdict and keeps saturating good/dropped frame counters.
package rx_frame_sequencer_pkg;
    typedef logic [7:0] byte_t;
endpackage

module rx_frame_sequencer
    import rx_frame_sequencer_pkg::*;
#(
    parameter int BYTE_GAP        = 4,
    parameter int MAX_FRAME_BYTES = 1500,
    parameter int RESULT_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  byte_t       s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic        s_tready,
    output byte_t       eth_data_in,
    output logic        eth_byte_valid,
    output logic        eth_eof,
    output logic        eth_err,
    input  logic        ip_eof,
    input  logic        ip_err,
    output logic        busy,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);
    localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam int LEN_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int TMR_W = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, WAIT} state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [15:0]        ok_cnt, drop_cnt;
    logic               hs, fwd, eof_d, err_d, ok_inc, drop_inc, ready_d;

    assign hs             = s_tvalid && s_tready;
    assign frames_ok      = ok_cnt;
    assign frames_dropped = drop_cnt;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        gap_d    = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        len_d    = len_q;
        tmr_d    = tmr_q;
        fwd      = 1'b0;
        eof_d    = 1'b0;
        err_d    = 1'b0;
        ok_inc   = 1'b0;
        drop_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && s_tvalid) begin
                    state_d = FEED;
                    len_d   = '0;
                end
            end
            FEED: begin
                if (hs) gap_d = GAP_W'(BYTE_GAP - 1);
                // A verdict of rejection wins over the byte arriving in the same cycle.
                if (ip_err) begin
                    drop_inc = 1'b1;
                    state_d  = (hs && s_tlast) ? IDLE : FLUSH;
                end else if (hs) begin
                    fwd   = 1'b1;
                    len_d = len_q + 1'b1;
                    if (s_tlast) begin
                        eof_d   = 1'b1;
                        err_d   = s_tuser;
                        tmr_d   = '0;
                        state_d = WAIT;
                    end else if (len_q == LEN_W'(MAX_FRAME_BYTES - 1)) begin
                        eof_d    = 1'b1;
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (hs && s_tlast) state_d = IDLE;
            end
            WAIT: begin
                if (ip_err) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else if (ip_eof) begin
                    ok_inc  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_q == TMR_W'(RESULT_TIMEOUT - 1)) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == FLUSH) || ((state_d == FEED) && (gap_d == '0));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            gap_q          <= '0;
            len_q          <= '0;
            tmr_q          <= '0;
            ok_cnt         <= '0;
            drop_cnt       <= '0;
            s_tready       <= 1'b0;
            eth_data_in    <= '0;
            eth_byte_valid <= 1'b0;
            eth_eof        <= 1'b0;
            eth_err        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            len_q          <= len_d;
            tmr_q          <= tmr_d;
            s_tready       <= ready_d;
            eth_byte_valid <= fwd;
            eth_eof        <= eof_d;
            eth_err        <= err_d;
            busy           <= (state_d != IDLE);
            if (fwd) eth_data_in <= s_tdata;
            if (ok_inc && (ok_cnt != 16'hFFFF)) ok_cnt <= ok_cnt + 1'b1;
            if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Scoreboard bench for rx_frame_sequencer: stimulus pushes expected strobes, a negedge monitor pops and compares.
// Two instances differ only in MAX_FRAME_BYTES; sel routes stimulus and monitoring to one of them.
module tb_rx_frame_sequencer;
    localparam int BYTE_GAP = 4;

    typedef struct {
        logic [7:0] data;
        logic       eof;
        logic       err;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, enable, sel;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tuser, ip_eof, ip_err;

    logic       ready_a, valid_a, eof_a, err_a, busy_a;
    logic       ready_b, valid_b, eof_b, err_b, busy_b;
    logic [7:0] data_a, data_b;
    logic [15:0] ok_a, drop_a, ok_b, drop_b;

    logic       m_ready, m_valid, m_eof, m_err, m_busy;
    logic [7:0] m_data;
    logic [15:0] m_ok, m_drop;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    logic [15:0] exp_ok = 0;
    logic [15:0] exp_drop = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_frame_sequencer #(.BYTE_GAP(BYTE_GAP), .MAX_FRAME_BYTES(1500), .RESULT_TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid && !sel), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tready(ready_a), .eth_data_in(data_a), .eth_byte_valid(valid_a), .eth_eof(eof_a),
        .eth_err(err_a), .ip_eof(ip_eof && !sel), .ip_err(ip_err && !sel), .busy(busy_a),
        .frames_ok(ok_a), .frames_dropped(drop_a)
    );

    rx_frame_sequencer #(.BYTE_GAP(BYTE_GAP), .MAX_FRAME_BYTES(32), .RESULT_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tready(ready_b), .eth_data_in(data_b), .eth_byte_valid(valid_b), .eth_eof(eof_b),
        .eth_err(err_b), .ip_eof(ip_eof && sel), .ip_err(ip_err && sel), .busy(busy_b),
        .frames_ok(ok_b), .frames_dropped(drop_b)
    );

    assign m_ready = sel ? ready_b : ready_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_eof   = sel ? eof_b   : eof_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_data  = sel ? data_b  : data_a;
    assign m_ok    = sel ? ok_b    : ok_a;
    assign m_drop  = sel ? drop_b  : drop_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_data", {24'd0, m_data}, {24'd0, mon_e.data});
                check("strobe_eof", {31'd0, m_eof}, {31'd0, mon_e.eof});
                check("strobe_err", {31'd0, m_err}, {31'd0, mon_e.err});
                if (mon_e.gap > 0) check("strobe_gap", cyc - last_strobe, mon_e.gap);
            end
            last_strobe = cyc;
        end
    end

    // Drives one frame through the FIFO side and records the strobes it must produce.
    task automatic send_frame(input int n, input logic [7:0] seed, input logic tuser,
                              input int err_after, input int limit, input int abort_after,
                              input int gap);
        int   i = 1;
        int   budget = n * (BYTE_GAP + 2) + 20;
        bit   fwd = 1'b1;
        logic hs;
        exp_t e;
        while (i <= n) begin
            s_tvalid = 1'b1;
            s_tdata  = seed + 8'(i);
            s_tlast  = (i == n);
            s_tuser  = tuser && (i == n);
            @(negedge clk);
            hs = m_ready;
            @(posedge clk);
            #1;
            ip_err = 1'b0;
            if (hs) begin
                if (fwd) begin
                    e.data = s_tdata;
                    e.gap  = (i == 1) ? 0 : gap;
                    e.eof  = 1'b0;
                    e.err  = 1'b0;
                    if (i == n) begin
                        e.eof = 1'b1;
                        e.err = tuser;
                    end else if (i == limit) begin
                        e.eof = 1'b1;
                        e.err = 1'b1;
                        fwd   = 1'b0;
                    end
                    sb_q.push_back(e);
                end
                if (i == err_after) begin
                    ip_err = 1'b1;
                    fwd    = 1'b0;
                end
                if (i == abort_after) begin
                    rst_n = 1'b0;
                    break;
                end
                i++;
            end
            budget--;
            if (budget == 0) begin
                check("frame_budget", 32'd0, 32'd1);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic verdict(input logic eof, input logic err);
        @(posedge clk); #1;
        ip_eof = eof;
        ip_err = err;
        @(negedge clk);
        check("busy_before_verdict", {31'd0, m_busy}, 32'd1);
        @(posedge clk); #1;
        ip_eof = 1'b0;
        ip_err = 1'b0;
        @(negedge clk);
        check("busy_after_verdict", {31'd0, m_busy}, 32'd0);
    endtask

    task automatic check_counters();
        check("frames_ok", {16'd0, m_ok}, {16'd0, exp_ok});
        check("frames_dropped", {16'd0, m_drop}, {16'd0, exp_drop});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; sel = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        ip_eof = 1'b0; ip_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tready", {31'd0, m_ready}, 32'd0);
        check("reset_valid", {31'd0, m_valid}, 32'd0);
        check("reset_busy", {31'd0, m_busy}, 32'd0);
        check("reset_data", {24'd0, m_data}, 32'd0);
        check_counters();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good 40-byte frame, strobes paced by BYTE_GAP, accepted by the parser.
        send_frame(40, 8'h10, 1'b0, 0, 1500, 0, BYTE_GAP);
        verdict(1'b1, 1'b0);
        exp_ok = 1;
        check_counters();

        // MAC CRC error flagged on the last byte, parser rejects.
        send_frame(16, 8'h40, 1'b1, 0, 1500, 0, 0);
        verdict(1'b0, 1'b1);
        exp_drop = 1;
        check_counters();

        // Simultaneous eof and err is a rejection.
        send_frame(8, 8'h60, 1'b0, 0, 1500, 0, 0);
        verdict(1'b1, 1'b1);
        exp_drop = 2;
        check_counters();

        // Verdicts while idle are ignored.
        @(posedge clk); #1; ip_eof = 1'b1;
        @(posedge clk); #1; ip_eof = 1'b0; ip_err = 1'b1;
        @(posedge clk); #1; ip_err = 1'b0;
        @(negedge clk);
        check_counters();

        // Parser rejects after byte 5 of 75: rest drained silently.
        send_frame(75, 8'h80, 1'b0, 5, 1500, 0, 0);
        @(negedge clk);
        check("busy_after_flush", {31'd0, m_busy}, 32'd0);
        exp_drop = 3;
        check_counters();

        // Length overrun on the 32-byte-limit instance.
        sel = 1'b1;
        send_frame(40, 8'hC0, 1'b0, 0, 32, 0, 0);
        @(negedge clk);
        check("busy_after_overrun", {31'd0, m_busy}, 32'd0);
        check("overrun_dropped", {16'd0, m_drop}, 32'd1);
        check("overrun_ok", {16'd0, m_ok}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0;

        // No verdict: timeout after 64 cycles in WAIT.
        send_frame(6, 8'h20, 1'b0, 0, 1500, 0, 0);
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("busy_before_timeout", {31'd0, m_busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_timeout", {31'd0, m_busy}, 32'd0);
        exp_drop = 4;
        check_counters();

        // Disabled: a waiting byte must not start a frame.
        enable = 1'b0;
        s_tvalid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("disabled_tready", {31'd0, m_ready}, 32'd0);
        check("disabled_busy", {31'd0, m_busy}, 32'd0);
        s_tvalid = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a frame clears everything.
        send_frame(10, 8'h33, 1'b0, 0, 1500, 3, 0);
        @(posedge clk);
        @(negedge clk);
        check("midreset_tready", {31'd0, m_ready}, 32'd0);
        check("midreset_valid", {31'd0, m_valid}, 32'd0);
        check("midreset_eof_err", {30'd0, m_eof, m_err}, 32'd0);
        check("midreset_busy", {31'd0, m_busy}, 32'd0);
        check("midreset_data", {24'd0, m_data}, 32'd0);
        exp_ok = 0;
        exp_drop = 0;
        check_counters();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturation of the good-frame counter.
        force dut_a.ok_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut_a.ok_cnt;
        exp_ok = 16'hFFFE;
        @(negedge clk);
        check_counters();
        for (int k = 0; k < 3; k++) begin
            send_frame(4, 8'h50 + 8'(k * 16), 1'b0, 0, 1500, 0, 0);
            verdict(1'b1, 1'b0);
            if (exp_ok != 16'hFFFF) exp_ok = exp_ok + 1'b1;
            check_counters();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
